snake_vga_scan: RTL and testbench

Raster scan and pixel-colour stage for the snake game on a 640×480@60 Hz VGA output. The block generates the pixel coordinates `x_pos`/`y_pos` consumed by the snake-state logic and samples the returned 2-bit `snake` cell status plus an apple flag. It produces registered RGB and sync outputs, and owns the `die_flash` blink signal that the snake logic uses to hide the snake after a collision.

---
 rtl/snake_vga_pkg.sv | 32 +++
 rtl/vga_timing.sv | 55 +++++
 rtl/snake_vga_scan.sv | 99 +++++++++
 tb/tb_snake_vga_scan.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_vga_pkg.sv
// Shared codes and 640x480@60 timing constants for the snake VGA scan stage.
// Used by snake_vga_scan (optional grid background: SNAKE_VGA_GRID_EN).
package snake_vga_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10,
    WALL = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    RESTART = 2'b00,
    START   = 2'b01,
    PLAY    = 2'b10
  } game_e;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] GRID_RGB = 12'h222;

endpackage

// File: rtl/vga_timing.sv
// Pixel enable, H/V raster counters, raw (unregistered) sync/active decode
// and the frame_start pulse for the snake VGA scan stage.
module vga_timing
  import snake_vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       active,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST  = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST  = V_TOTAL - 10'd1;
  localparam logic [9:0] HS_BEG  = H_ACTIVE + H_FP;
  localparam logic [9:0] HS_END  = HS_BEG + H_SYNC;
  localparam logic [9:0] VS_BEG  = V_ACTIVE + V_FP;
  localparam logic [9:0] VS_END  = VS_BEG + V_SYNC;

  logic       pix_q;
  logic [9:0] x_q;
  logic [9:0] y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      pix_q <= ~pix_q;
      if (pix_q) begin
        if (x_q == H_LAST) begin
          x_q <= '0;
          y_q <= (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  assign pix_en      = pix_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign active      = (x_q < H_ACTIVE) && (y_q < V_ACTIVE);
  // Sync levels are active low; they are registered by the caller.
  assign hsync_raw   = !((x_q >= HS_BEG) && (x_q < HS_END));
  assign vsync_raw   = !((y_q >= VS_BEG) && (y_q < VS_END));
  assign frame_start = pix_q && (x_q == H_LAST) && (y_q == V_LAST);

endmodule

// File: rtl/snake_vga_scan.sv
// Snake game VGA scan: colour select, registered RGB/sync and die_flash blink.
// Define SNAKE_VGA_GRID_EN to draw a 16-pixel grid in the background.
module snake_vga_scan
  import snake_vga_pkg::*;
#(
  parameter int          FLASH_FRAMES = 15,
  parameter logic [11:0] WALL_RGB     = 12'h888,
  parameter logic [11:0] HEAD_RGB     = 12'hFF0,
  parameter logic [11:0] BODY_RGB     = 12'h0F0,
  parameter logic [11:0] APPLE_RGB    = 12'hF00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_status,
  input  logic       hit_body,
  input  logic       hit_wall,
  input  logic [1:0] snake,
  input  logic       apple,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       die_flash,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_FRAMES - 1);

  logic        pix_en;
  logic        active;
  logic        hsync_raw;
  logic        vsync_raw;
  logic [11:0] colour;
  logic [11:0] rgb_q;
  logic [CW-1:0] cnt;

  vga_timing u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .active      (active),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .frame_start (frame_start)
  );

  always_comb begin
    colour = '0;
    if (active) begin
      case (snake)
        WALL:    colour = WALL_RGB;
        HEAD:    colour = HEAD_RGB;
        BODY:    colour = BODY_RGB;
        default: begin
          if (apple) colour = APPLE_RGB;
`ifdef SNAKE_VGA_GRID_EN
          else if ((x_pos[3:0] == 4'd0) || (y_pos[3:0] == 4'd0)) colour = GRID_RGB;
`endif
        end
      endcase
    end
  end

  // RGB and both syncs share one register stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      rgb_q <= colour;
      hsync <= hsync_raw;
      vsync <= vsync_raw;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;

  always_ff @(posedge clk) begin
    if (rst || (game_status == RESTART) || !(hit_body || hit_wall)) begin
      die_flash <= 1'b1;
      cnt       <= '0;
    end else if (frame_start) begin
      if (cnt == CNT_LAST) begin
        die_flash <= ~die_flash;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_vga_scan.sv
// Self-checking bench for snake_vga_scan: pixel-index reference model plus
// directed vector table and multi-cycle sequences (coordinate jumps via force).
module tb_snake_vga_scan;

  localparam int F = 3;
  localparam int PIX_FRAME = 800 * 525;
`ifdef SNAKE_VGA_GRID_EN
  localparam logic [11:0] GRID_EXP = 12'h222;
`else
  localparam logic [11:0] GRID_EXP = 12'h000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] game_status;
  logic       hit_body, hit_wall;
  logic [1:0] snake;
  logic       apple;
  logic [9:0] x_pos, y_pos;
  logic       die_flash, frame_start, hsync, vsync;
  logic [3:0] vga_r, vga_g, vga_b;

  snake_vga_scan #(.FLASH_FRAMES(F)) dut (
    .clk(clk), .rst(rst), .game_status(game_status), .hit_body(hit_body),
    .hit_wall(hit_wall), .snake(snake), .apple(apple), .x_pos(x_pos),
    .y_pos(y_pos), .die_flash(die_flash), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int npass = 0, ntotal = 0;

  // Reference model state: linear pixel index into the frame.
  int          m_p;
  bit          m_pix;
  logic [11:0] m_rgb;
  bit          m_hs, m_vs;
  int          m_frames;
  bit          fs_seen;
  logic [9:0]  fx, fy;

  typedef struct {
    int          x;
    int          y;
    logic [1:0]  snake;
    logic        apple;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic logic [11:0] ref_rgb(input int x, input int y,
                                          input logic [1:0] s, input logic a);
    if (x >= 640 || y >= 480) return 12'h000;
    if (s == 2'd3) return 12'h888;
    if (s == 2'd1) return 12'hFF0;
    if (s == 2'd2) return 12'h0F0;
    if (a)         return 12'hF00;
    if ((x % 16 == 0) || (y % 16 == 0)) return GRID_EXP;
    return 12'h000;
  endfunction

  task automatic step();
    bit pre_fs;
    int x, y;
    pre_fs = m_pix && (m_p == PIX_FRAME - 1);
    @(posedge clk);
    fs_seen = 1'b0;
    if (rst) begin
      m_p = 0; m_pix = 0; m_rgb = 0; m_hs = 1; m_vs = 1; m_frames = 0;
    end else begin
      if (m_pix) begin
        x = m_p % 800;
        y = m_p / 800;
        m_rgb = ref_rgb(x, y, snake, apple);
        m_hs  = !(x >= 656 && x <= 751);
        m_vs  = !(y >= 490 && y <= 491);
        m_p   = (m_p + 1) % PIX_FRAME;
      end
      m_pix = !m_pix;
      if (game_status == 2'b00 || !(hit_body || hit_wall)) m_frames = 0;
      else if (pre_fs) m_frames++;
      fs_seen = pre_fs;
    end
    #1;
    check("cycle",
          {28'd0, x_pos, y_pos, frame_start, hsync, vsync, vga_r, vga_g, vga_b, die_flash},
          {28'd0, 10'(m_p % 800), 10'(m_p / 800),
           1'(m_pix && m_p == PIX_FRAME - 1), 1'(m_hs), 1'(m_vs), m_rgb,
           1'(((m_frames / F) % 2) == 0)});
  endtask

  task automatic jump(input int jx, input int jy);
    if (m_pix) step();
    fx = 10'(jx);
    fy = 10'(jy);
    force dut.u_timing.x_q = fx;
    force dut.u_timing.y_q = fy;
    #1;
    release dut.u_timing.x_q;
    release dut.u_timing.y_q;
    m_p = jy * 800 + jx;
  endtask

  // Jump near end of frame and run until one frame_start edge has been taken.
  task automatic next_frame(input logic exp_flash, input string nm);
    int n;
    jump(790, 524);
    n = 0;
    fs_seen = 1'b0;
    while (!fs_seen && n < 40) begin
      step();
      n++;
    end
    check({nm, "_pulse_seen"}, 64'(fs_seen), 64'd1);
    check(nm, 64'(die_flash), 64'(exp_flash));
  endtask

  initial begin
    int lows;
    int jx, jy;

    vecs[0]  = '{160,  80, 2'd1, 1'b1, 12'hFF0};
    vecs[1]  = '{160,  80, 2'd0, 1'b1, 12'hF00};
    vecs[2]  = '{160,  80, 2'd2, 1'b1, 12'h0F0};
    vecs[3]  = '{160,  80, 2'd3, 1'b1, 12'h888};
    vecs[4]  = '{639, 479, 2'd3, 1'b0, 12'h888};
    vecs[5]  = '{640, 100, 2'd3, 1'b0, 12'h000};
    vecs[6]  = '{100, 480, 2'd3, 1'b1, 12'h000};
    vecs[7]  = '{799, 524, 2'd1, 1'b0, 12'h000};
    vecs[8]  = '{ 32,  40, 2'd0, 1'b0, GRID_EXP};
    vecs[9]  = '{ 33,  40, 2'd0, 1'b0, 12'h000};
    vecs[10] = '{ 33,  48, 2'd0, 1'b0, GRID_EXP};
    vecs[11] = '{  0,   0, 2'd0, 1'b1, 12'hF00};

    rst = 1; game_status = 2'b10; hit_body = 0; hit_wall = 0; snake = 0; apple = 0;
    m_p = 0; m_pix = 0; m_rgb = 0; m_hs = 1; m_vs = 1; m_frames = 0; fs_seen = 0;
    fx = 0; fy = 0;
    #2;
    repeat (3) step();
    check("reset_state",
          {x_pos, y_pos, frame_start, hsync, vsync, vga_r, vga_g, vga_b, die_flash},
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1});

    // Free run across the first line: x wrap and hsync low width.
    rst = 0;
    lows = 0;
    for (int i = 0; i < 1700; i++) begin
      snake = 2'($urandom_range(0, 3));
      apple = 1'($urandom_range(0, 1));
      step();
      if (i >= 100 && !hsync) lows++;
    end
    check("hsync_low_clks", 64'(lows), 64'd192);

    foreach (vecs[i]) begin
      jump(vecs[i].x, vecs[i].y);
      snake = vecs[i].snake;
      apple = vecs[i].apple;
      step();
      step();
      check($sformatf("vec%0d_rgb", i), 64'({vga_r, vga_g, vga_b}), 64'(vecs[i].rgb));
    end

    // Blanking with WALL held, plus vsync low width around the sync lines.
    snake = 2'd3; apple = 0;
    jump(0, 487);
    lows = 0;
    for (int i = 0; i < 9600; i++) begin
      step();
      if (!vsync) lows++;
    end
    check("vsync_low_clks", 64'(lows), 64'd3200);

    // Frame wrap: exactly one frame_start, counters return to 0,0.
    jump(795, 524);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (frame_start) lows++;
    end
    check("frame_start_count", 64'(lows), 64'd1);
    check("frame_wrap_y", 64'(y_pos), 64'd0);

    // Death flash with hit_wall held.
    snake = 0;
    hit_wall = 1;
    next_frame(1, "flash_p1");
    next_frame(1, "flash_p2");
    next_frame(0, "flash_p3");
    next_frame(0, "flash_p4");
    next_frame(0, "flash_p5");
    next_frame(1, "flash_p6");
    next_frame(1, "flash_p7");
    next_frame(1, "flash_p8");
    next_frame(0, "flash_p9");
    game_status = 2'b00;
    step();
    check("flash_restart", 64'(die_flash), 64'd1);
    game_status = 2'b10;
    hit_wall = 0; hit_body = 1;
    next_frame(1, "flash_b1");
    next_frame(1, "flash_b2");
    next_frame(0, "flash_b3");
    next_frame(0, "flash_b4");
    hit_body = 0;
    step();
    check("flash_drop", 64'(die_flash), 64'd1);

    // Mid-frame reset.
    snake = 2'd3;
    jump(300, 200);
    step(); step(); step();
    rst = 1;
    step();
    check("midreset",
          {34'd0, x_pos, y_pos, hsync, vsync, vga_r, vga_g, vga_b},
          {34'd0, 10'd0, 10'd0, 1'b1, 1'b1, 12'h000});
    rst = 0;

    // Randomised run against the model.
    for (int i = 0; i < 6000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: begin jx = $urandom_range(0, 799);   jy = $urandom_range(0, 524);   end
          1: begin jx = $urandom_range(630, 660); jy = $urandom_range(0, 524);   end
          2: begin jx = $urandom_range(745, 799); jy = $urandom_range(475, 524); end
          default: begin jx = $urandom_range(780, 799); jy = 524; end
        endcase
        jump(jx, jy);
      end
      if ($urandom_range(0, 299) == 0) game_status = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) hit_wall = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) hit_body = 1'($urandom_range(0, 1));
      snake = 2'($urandom_range(0, 3));
      apple = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
